// File: rtl/eeprom_access_arbiter_if.sv
// Engine-side bus of the EEPROM access arbiter.
// master = arbiter, slave = serial read/write engine.
interface eeprom_access_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output wr, rd, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  wr, rd, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/eeprom_access_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the EEPROM engine.
// Optional WAIT watchdog: define EEPROM_ARB_TIMEOUT_EN.
module eeprom_access_arbiter #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  eeprom_access_arbiter_if.master eng,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int S_IDLE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_WAIT  = 2;
  localparam int S_DONE  = 3;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   rw_q;
  logic   gnt;
  logic   gnt_rw;

  // Contention goes to whoever did not win last time.
  assign gnt    = (r0_req && r1_req) ? ~last_grant
                                     : r1_req;
  assign gnt_rw = gnt ? r1_rw : r0_rw;

`ifdef EEPROM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign r0_err = 1'b0;
  assign r1_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rw_q       <= 1'b0;
      busy       <= 1'b0;
      eng.wr     <= 1'b0;
      eng.rd     <= 1'b0;
      eng.addr   <= '0;
      eng.wdata  <= '0;
      r0_done    <= 1'b0;
      r1_done    <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
`ifdef EEPROM_ARB_TIMEOUT_EN
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      eng.wr  <= 1'b0;
      eng.rd  <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
      r0_err  <= 1'b0;
      r1_err  <= 1'b0;
`endif
      unique case (1'b1)
        state[S_IDLE]: begin
          if (r0_req || r1_req) begin
            owner      <= gnt;
            last_grant <= gnt;
            rw_q       <= gnt_rw;
            eng.addr   <= gnt ? r1_addr : r0_addr;
            eng.wdata  <= gnt ? r1_wdata : r0_wdata;
            eng.wr     <= ~gnt_rw;
            eng.rd     <= gnt_rw;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        state[S_ISSUE]: begin
          state <= WAIT;
`ifdef EEPROM_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        state[S_WAIT]: begin
          if (eng.ack) begin
            if (rw_q && !owner) r0_rdata <= eng.rdata;
            if (rw_q && owner)  r1_rdata <= eng.rdata;
            r0_done <= ~owner;
            r1_done <= owner;
            state   <= DONE;
          end
`ifdef EEPROM_ARB_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            r0_done <= ~owner;
            r1_done <= owner;
            r0_err  <= ~owner;
            r1_err  <= owner;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        state[S_DONE]: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/eeprom_access_arbiter.md
Name: eeprom_access_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single EEPROM serial read/write engine.
- Each requester posts a byte read or write with an 11-bit address.
- The arbiter grants one request at a time, pulses the engine's WR or RD strobe and waits for the engine's end-of-cycle ACK.
- It then returns completion, and read data for reads, to the owning requester.

Parameters:
- ADDR_W, 11, EEPROM byte address width (matches engine ADDR).
- DATA_W, 8, data byte width.
- TIMEOUT_CYCLES, 4096, watchdog limit in CLK cycles for WAIT; used only with the optional feature.

Ports:
- CLK  input  1  system clock (engine runs on the same clock).
- RESET  input  1  synchronous, active-high reset.
- r0_req  input  1  requester 0 request; held high until r0_done.
- r0_rw  input  1  requester 0 operation: 1=read, 0=write.
- r0_addr  input  ADDR_W  requester 0 byte address.
- r0_wdata  input  DATA_W  requester 0 write byte.
- r0_done  output  1  one-cycle completion pulse to requester 0.
- r0_err  output  1  one-cycle timeout flag, coincident with r0_done.
- r0_rdata  output  DATA_W  last read byte for requester 0.
- r1_req, r1_rw, r1_addr, r1_wdata, r1_done, r1_err, r1_rdata: identical set for requester 1.
- eng_wr  output  1  one-cycle write strobe to engine.
- eng_rd  output  1  one-cycle read strobe to engine.
- eng_addr  output  ADDR_W  registered address to engine, stable from ISSUE through DONE.
- eng_wdata  output  DATA_W  registered write byte, stable from ISSUE through DONE.
- eng_rdata  input  DATA_W  engine read data, valid while eng_ack is high.
- eng_ack  input  1  engine end-of-operation pulse.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so requester 0 wins the first contention; captured address/data/rw regs cleared.
- One-hot FSM with four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample r0_req and r1_req.
  - If both are high, grant the requester not equal to last_grant.
  - If only one is high, grant it.
  - On grant: capture addr, wdata, rw and the owner id into registers; set last_grant=owner; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Assert eng_wr if captured rw=0, or eng_rd if rw=1. Never both.
  - Go to WAIT.
- WAIT:
  - Hold eng_wr and eng_rd at 0; eng_addr and eng_wdata stay stable.
  - On eng_ack=1: if the op is a read, load eng_rdata into the owner's rN_rdata. Go to DONE.
- DONE (exactly 1 cycle):
  - Pulse the owner's rN_done.
  - Go to IDLE.
- Latency: request high in IDLE cycle t gives the strobe at t+1. eng_ack at cycle a gives rN_done at a+1; busy falls at a+2.
- eng_ack outside WAIT is ignored, and any stray ack causes no state change.
- Requester contract: deassert rN_req in the cycle after rN_done. If it is still high in IDLE, it is taken as a new request.
- Request dropped before grant: no operation, no done.
- Request dropped after grant: the operation completes and done still pulses.
- The non-owner request stays pending, with no timeout and no starvation. Strict alternation under continuous contention: r0, r1, r0, ...
- rN_rdata holds its value until the next read completes for that requester. Writes do not alter it.
- RESET mid-operation: return to IDLE immediately. Strobes and done are not issued, and no error is flagged. The engine is reset by the same RESET.

Optional Feature:
- Macro EEPROM_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without eng_ack, go to DONE and pulse rN_err together with rN_done.
  - rN_rdata is left unchanged.
  - If eng_ack arrives in the same cycle as expiry, ack wins and no error is flagged.
- When undefined: no counter is built, rN_err is tied to 0, and WAIT lasts indefinitely.

Test Plan:
- Reset then r0 write addr=11'h155 wdata=8'hA5 -> eng_wr pulses 1 cycle with eng_addr=11'h155 and eng_wdata=8'hA5; ack 30 cycles later -> r0_done at ack+1, r1_done=0, busy low at ack+2.
- r1 read addr=11'h7FF, engine returns 8'h3C with ack -> eng_rd pulse only; r1_rdata=8'h3C at done; r0_rdata unchanged at 8'h00.
- r0_req and r1_req rise in the same cycle, both held for three operations each -> grant order r0, r1, r0, r1, r0, r1; exactly six done pulses.
- Stray eng_ack in IDLE and ISSUE -> no state change, no done; a pending request is still strobed normally.
- RESET asserted in WAIT -> next cycle state IDLE, busy=0, all outputs 0; a later request operates normally.
- EEPROM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no ack -> r0_done and r0_err pulse together 16 cycles after entering WAIT. Without the macro, the same stimulus keeps busy high and r0_err stays 0.
